// File: rtl/music_seq_player.sv
// UART-loaded note sequencer: stores {tone,dur} bytes in an on-chip buffer and
// plays them back with millisecond timing; a direct mode drives the tone per byte.
module music_seq_player #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int DEPTH    = 128,
    parameter int TONE_W   = 5,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [1:0]        mode,
    input  logic              loop_en,
    input  logic              uart_done,
    input  logic [7:0]        uart_recv_data,
    output logic [TONE_W-1:0] music_tone,
    output logic [AW:0]       note_count,
    output logic [AW-1:0]     note_idx,
    output logic              busy,
    output logic              overflow,
    output logic              song_end
);
    localparam int TICK = CLK_FREQ / 1000;
    localparam int TW   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_DIRECT, S_LOAD, S_FETCH, S_START, S_HOLD, S_DONE
    } state_t;

    state_t            r_state;
    logic [TONE_W-1:0] r_tone;
    logic [AW:0]       r_note_count;
    logic [AW-1:0]     r_note_idx;
    logic              r_busy;
    logic              r_overflow;
    logic              r_song_end;
    logic              r_d0;
    logic              r_d1;
    logic [TW-1:0]     r_tick;
    logic [11:0]       r_dur;
    logic [7:0]        r_rd_data;
    logic [7:0]        r_buf [DEPTH];

    logic w_rx;
    logic w_full;
    logic w_wr_en;
    logic w_in_play;
    logic w_start_end;
    logic w_hold_done;
    logic w_hold_end;
    logic w_seq_end;

    function automatic logic [11:0] dur_ms(input logic [2:0] code);
        case (code)
            3'd1:    dur_ms = 12'd200;
            3'd2:    dur_ms = 12'd500;
            3'd3:    dur_ms = 12'd1000;
            3'd4:    dur_ms = 12'd2000;
            3'd5:    dur_ms = 12'd4000;
            3'd6:    dur_ms = 12'd100;
            3'd7:    dur_ms = 12'd3000;
            default: dur_ms = 12'd0;
        endcase
    endfunction

    // uart_done is a strobe with data held stable >=2 cycles after its rise;
    // only the rising edge counts as a received byte.
    assign w_rx      = r_d0 & ~r_d1;
    assign w_full    = (r_note_count == FULL_CNT);
    assign w_wr_en   = (mode == 2'd2) && (r_state == S_LOAD) && w_rx && !w_full;
    assign w_in_play = (r_state == S_FETCH) || (r_state == S_START) ||
                       (r_state == S_HOLD)  || (r_state == S_DONE);

    assign w_start_end = (r_state == S_START) &&
                         ((r_rd_data[2:0] == 3'd0) || ({1'b0, r_note_idx} >= r_note_count));
    assign w_hold_done = (r_state == S_HOLD) && (r_tick == TICK_LAST) && (r_dur == 12'd0);
    assign w_hold_end  = w_hold_done && ({1'b0, r_note_idx} == r_note_count - 1'b1);
    assign w_seq_end   = w_start_end || w_hold_end;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_d0 <= 1'b0;
            r_d1 <= 1'b0;
        end else begin
            r_d0 <= uart_done;
            r_d1 <= r_d0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr_en)
            r_buf[r_note_count[AW-1:0]] <= uart_recv_data;
        r_rd_data <= r_buf[r_note_idx];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state      <= S_IDLE;
            r_tone       <= '0;
            r_note_count <= '0;
            r_note_idx   <= '0;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
            r_song_end   <= 1'b0;
            r_tick       <= '0;
            r_dur        <= '0;
        end else begin
            r_song_end <= 1'b0;
            case (mode)
                2'd0: begin
                    r_state <= S_IDLE;
                    r_tone  <= '0;
                    r_busy  <= 1'b0;
                end
                2'd1: begin
                    r_state <= S_DIRECT;
                    r_busy  <= 1'b0;
                    if (r_state == S_DIRECT && w_rx)
                        r_tone <= uart_recv_data[7 -: TONE_W];
                end
                2'd2: begin
                    r_busy <= 1'b0;
                    r_tone <= '0;
                    if (r_state != S_LOAD) begin
                        r_state      <= S_LOAD;
                        r_note_count <= '0;
                        r_overflow   <= 1'b0;
                    end else if (w_rx) begin
                        if (w_full)
                            r_overflow <= 1'b1;
                        else
                            r_note_count <= r_note_count + 1'b1;
                    end
                end
                default: begin
                    if (!w_in_play) begin
                        r_state    <= S_FETCH;
                        r_note_idx <= '0;
                        r_busy     <= 1'b1;
                    end else if (w_seq_end) begin
                        if (loop_en) begin
                            r_note_idx <= '0;
                            r_state    <= S_FETCH;
                        end else begin
                            r_song_end <= 1'b1;
                            r_tone     <= '0;
                            r_busy     <= 1'b0;
                            r_state    <= S_DONE;
                        end
                    end else begin
                        case (r_state)
                            S_FETCH: r_state <= S_START;
                            S_START: begin
                                r_tone  <= r_rd_data[7 -: TONE_W];
                                r_dur   <= dur_ms(r_rd_data[2:0]) - 12'd1;
                                r_tick  <= '0;
                                r_state <= S_HOLD;
                            end
                            S_HOLD: begin
                                if (r_tick == TICK_LAST) begin
                                    r_tick <= '0;
                                    if (r_dur == 12'd0) begin
                                        r_note_idx <= r_note_idx + 1'b1;
                                        r_state    <= S_FETCH;
                                    end else begin
                                        r_dur <= r_dur - 12'd1;
                                    end
                                end else begin
                                    r_tick <= r_tick + 1'b1;
                                end
                            end
                            default: r_state <= r_state;
                        endcase
                    end
                end
            endcase
        end
    end

    assign music_tone = r_tone;
    assign note_count = r_note_count;
    assign note_idx   = r_note_idx;
    assign busy       = r_busy;
    assign overflow   = r_overflow;
    assign song_end   = r_song_end;
endmodule

// File: doc/music_seq_player.md
Name: music_seq_player

Overview:
- Parametrised successor to the UART tone player.
- Runs in a single sys_clk domain with an internal 1 ms tick, replacing the external clk_1ms input.
- Stores UART-received note bytes in an on-chip note buffer and plays them back as a timed sequence, with optional looping; a direct mode drives the tone straight from UART bytes.
- Output music_tone feeds the existing tone/frequency generator.

Parameters:
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz; ms tick period TICK = CLK_FREQ/1000 cycles.
- DEPTH, 128, note buffer entries (power of 2, 2..256); AW = clog2(DEPTH) is derived locally.
- TONE_W, 5, tone code width; note byte = {tone[TONE_W-1:0], dur[2:0]}, so TONE_W+3 <= 8 and the upper bits are used.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous reset, active-high.
- mode  in  2  0 STOP, 1 DIRECT, 2 LOAD, 3 PLAY (static switch input, same clock domain).
- loop_en  in  1  1 = restart the sequence after the last note.
- uart_done  in  1  UART byte-received strobe; its rising edge is detected internally.
- uart_recv_data  in  8  received byte, stable from uart_done rise for >=2 cycles.
- music_tone  out  TONE_W  tone code, 0 = silence.
- note_count  out  AW+1  notes stored, 0..DEPTH.
- note_idx  out  AW  buffer index being played.
- busy  out  1  high in PLAY_START/PLAY_HOLD/PLAY_FETCH.
- overflow  out  1  sticky: a byte arrived in LOAD while the buffer was full.
- song_end  out  1  one-cycle pulse when a non-looping sequence finishes.

Behaviour:
- Reset (async, sys_rst=1):
  - music_tone=0, note_count=0, note_idx=0, busy=0, overflow=0, song_end=0.
  - State goes to IDLE and tick/duration counters clear.
  - Buffer contents are undefined and not cleared.
- Edge detect: d0<=uart_done, d1<=d0; rx = d0 & ~d1. An action on rx takes effect on the 2nd rising edge after uart_done is first sampled high.
- Duration code to ms: 0 END, 1 200, 2 500, 3 1000, 4 2000, 5 4000, 6 100, 7 3000. A note lasts exactly ms*TICK cycles in PLAY_HOLD.
- The state machine re-evaluates mode every cycle; a mode change aborts the current activity on the next edge.
- IDLE (mode 0): music_tone=0; rx ignored.
- DIRECT (mode 1): on rx, music_tone <= uart_recv_data[7:8-TONE_W]; the buffer is untouched.
- LOAD (mode 2):
  - Entering LOAD from any other mode clears note_count and overflow; music_tone=0.
  - On rx with note_count<DEPTH: buf[note_count] <= byte, note_count++.
  - On rx with note_count==DEPTH: byte dropped, overflow<=1.
  - Re-entering LOAD always starts a new song; there is no append.
- PLAY (mode 3), sub-states PLAY_FETCH -> PLAY_START -> PLAY_HOLD:
  - Entry: note_idx=0, go to PLAY_FETCH; busy=1.
  - PLAY_FETCH (1 cycle): buffer read address = note_idx (synchronous RAM). music_tone keeps its previous value.
  - PLAY_START (1 cycle): if dur==0 (END) or note_idx>=note_count, it is end of sequence. Otherwise latch music_tone <= tone field, load the duration counter, and clear the tick counter.
  - PLAY_HOLD: count ms*TICK cycles. Then, if note_idx==note_count-1, it is end of sequence; otherwise note_idx++ and go to PLAY_FETCH.
  - Note-to-note period = ms*TICK + 2 cycles.
  - End of sequence with loop_en=1: note_idx<=0, go to PLAY_FETCH, no song_end pulse.
  - End of sequence with loop_en=0: song_end pulses for 1 cycle, music_tone<=0, go to PLAY_DONE.
  - PLAY_DONE: busy=0, tone 0. Stays until mode leaves 3; re-entering mode 3 replays from index 0.
  - note_count==0 on entry: PLAY_FETCH -> PLAY_START -> end of sequence (song_end if loop_en=0). With loop_en=1 it spins FETCH/START with tone 0, which is allowed.
  - rx in PLAY is ignored; the buffer is never written.
- note_count/note_idx arithmetic:
  - note_count is AW+1 bits, so DEPTH is representable.
  - note_idx is AW bits and only increments when < note_count-1, so it cannot wrap.
- Simultaneous events: a mode change on the same cycle as rx follows the new mode's rule on the next cycle; that rx is lost.
- Reset mid-PLAY: everything returns to reset values immediately; note_count=0, so the stored song must be reloaded.

Test Plan:
- Sim with CLK_FREQ=10_000 (TICK=10) and DEPTH=4 throughout.
- Reset, mode=1, send byte 0x51 -> music_tone=10 on the 2nd edge after uart_done rise; busy=0, note_count=0.
- mode=2, send 0x31,0x39,0x46 -> note_count=3, overflow=0; send 2 more bytes -> note_count=4, overflow=1; mode 2->0->2 -> note_count=0, overflow=0.
- Load 0x31,0x4E (tones 6,9; dur 1,6), mode=3, loop_en=0 -> tone 6 held 2000 cycles, tone 9 held 1000 cycles, then song_end one-cycle pulse, music_tone=0, busy=0.
- Same song with loop_en=1 -> after tone 9, tone 6 reappears 2 cycles later; no song_end; note_idx sequence 0,1,0,1.
- Load 0x31,0x38,0x41 (middle byte dur=0 END) -> plays tone 6 only, then song_end; tone 8 is never output.
- Assert sys_rst mid-PLAY_HOLD -> music_tone=0, busy=0, note_count=0 asynchronously; deassert with mode=3 -> immediate end of sequence, song_end pulse.
